// File: rtl/comp_serial_ctrl_pkg.sv
// rtl/comp_serial_ctrl_pkg.sv - shared state encodings and defaults for the serial comparator
package comp_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/comp_1b.sv
// rtl/comp_1b.sv - single-bit equality comparator shared by the serial controller
module comp_1b (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = ~(a ^ b);

endmodule

// File: rtl/comp_serial_ctrl.sv
// rtl/comp_serial_ctrl.sv - bit-serial MSB-first word comparator around one comp_1b
module comp_serial_ctrl
  import comp_serial_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic [$clog2(WIDTH)-1:0] diff_idx
);

  localparam int IW = $clog2(WIDTH);

  state_t         state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]  idx;
  logic           mism;
  logic           hit_gt;
  logic           hit_lt;
  logic [IW-1:0]  hit_idx;

  logic a_bit;
  logic b_bit;
  logic eq_bit;
  logic hit_now;
  logic last;

  assign a_bit = a_reg[idx];
  assign b_bit = b_reg[idx];

  comp_1b u_cmp (
    .a  (a_bit),
    .b  (b_bit),
    .eq (eq_bit)
  );

  // Only the first (most significant) mismatch is recorded.
  assign hit_now = ~eq_bit & ~mism;
  assign last    = (EARLY_EXIT && hit_now) || (idx == '0);

  // Result flags stay low while scanning and are published on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      mism     <= 1'b0;
      hit_gt   <= 1'b0;
      hit_lt   <= 1'b0;
      hit_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      diff_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            idx      <= IW'(WIDTH - 1);
            mism     <= 1'b0;
            hit_gt   <= 1'b0;
            hit_lt   <= 1'b0;
            hit_idx  <= '0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            diff_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hit_now) begin
            mism    <= 1'b1;
            hit_idx <= idx;
            hit_gt  <= a_bit;
            hit_lt  <= ~a_bit;
          end
          if (last) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            eq       <= ~(mism | hit_now);
            gt       <= hit_now ? a_bit  : hit_gt;
            lt       <= hit_now ? ~a_bit : hit_lt;
            diff_idx <= hit_now ? idx    : hit_idx;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// tb/tb_comp_serial_ctrl.sv - scoreboard bench for comp_serial_ctrl, early-exit and full-scan instances
module tb_comp_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_i = 8'h00;
  logic [7:0] b_i = 8'h00;

  logic       busy0, done0, eq0, gt0, lt0;
  logic [2:0] idx0;
  logic       busy1, done1, eq1, gt1, lt1;
  logic [2:0] idx1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic e;
    logic g;
    logic l;
    int   idx;
    int   lat;
    int   t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] as, bs;
  logic pb0 = 1'b0;
  logic pb1 = 1'b0;

  comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0), .diff_idx(idx0)
  );

  comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1), .diff_idx(idx1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit early, input int t);
    exp_t r;
    r.e = 1'b1; r.g = 1'b0; r.l = 1'b0; r.idx = 0; r.lat = 9; r.t = t;
    for (int i = 7; i >= 0; i--) begin
      if (r.e && (a[i] != b[i])) begin
        r.e = 1'b0;
        r.g = a[i];
        r.l = b[i];
        r.idx = i;
        if (early) r.lat = 8 - i + 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    as = a_i;
    bs = b_i;
  end

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      pb0 = 1'b0;
    end else begin
      if (done0) begin
        if (q0.size() == 0) chk("u0_spurious_done", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("u0_eq", eq0, e0.e);
          chk("u0_gt", gt0, e0.g);
          chk("u0_lt", lt0, e0.l);
          chk("u0_diff_idx", idx0, e0.idx);
          chk("u0_latency", cyc - e0.t + 1, e0.lat);
        end
      end else if (busy0) begin
        chk("u0_flags_in_run", {eq0, gt0, lt0}, 0);
      end
      if (busy0 && !pb0) q0.push_back(model(as, bs, 1'b1, cyc));
      pb0 = busy0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      pb1 = 1'b0;
    end else begin
      if (done1) begin
        if (q1.size() == 0) chk("u1_spurious_done", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("u1_eq", eq1, e1.e);
          chk("u1_gt", gt1, e1.g);
          chk("u1_lt", lt1, e1.l);
          chk("u1_diff_idx", idx1, e1.idx);
          chk("u1_latency", cyc - e1.t + 1, e1.lat);
        end
      end else if (busy1) begin
        chk("u1_flags_in_run", {eq1, gt1, lt1}, 0);
      end
      if (busy1 && !pb1) q1.push_back(model(as, bs, 1'b0, cyc));
      pb1 = busy1;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy0 || busy1) chk("idle_timeout", 1, 0);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    a_i = a;
    b_i = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy0 || busy1 || q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_flags", {eq0, gt0, lt0}, 0);
    chk("rst_diff_idx", idx0, 0);
    chk("rst_u1_outputs", {busy1, done1, eq1, gt1, lt1, idx1}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_done", {done0, done1}, 0);
    end

    op(8'hA5, 8'hA5);
    op(8'h80, 8'h00);
    op(8'h12, 8'h13);
    op(8'h3C, 8'h34);
    op(8'h01, 8'hFF);
    op(8'hFE, 8'hFF);
    for (int i = 0; i < 4; i++) op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // operand change and extra start during RUN are both ignored
    op(8'h0F, 8'h0F);
    a_i = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("run_start_ignored_busy", busy0, 1);

    // held start: one idle cycle between operations
    wait_idle();
    a_i = 8'h40;
    b_i = 8'h20;
    start = 1'b1;
    n = 0;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", done0, 1);
    @(negedge clk);
    chk("b2b_idle_gap", busy0, 0);
    @(negedge clk);
    chk("b2b_restart", busy0, 1);
    start = 1'b0;
    drain();

    // asynchronous reset mid-RUN
    op(8'h55, 8'hAA);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {busy0, busy1}, 0);
    chk("arst_done", {done0, done1}, 0);
    chk("arst_flags", {eq0, gt0, lt0, eq1, gt1, lt1}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    op(8'h01, 8'h01);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
